// File: rtl/in_switch_pkg.sv
// Shared definitions for the in_switch 1-to-3 stream demultiplexer:
// route-select width, destination codes, FSM state encoding and the
// route-select saturation helper.
package in_switch_pkg;

  localparam int ROUTE_W = 2;

  localparam logic [ROUTE_W-1:0] DEST_0    = 2'd0;
  localparam logic [ROUTE_W-1:0] DEST_1    = 2'd1;
  localparam logic [ROUTE_W-1:0] DEST_2    = 2'd2;
  localparam logic [ROUTE_W-1:0] DEST_DROP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Out-of-range select 3 folds onto the last lane.
  function automatic logic [ROUTE_W-1:0] sat_dest(input logic [ROUTE_W-1:0] sel);
    return (sel == DEST_DROP) ? DEST_2 : sel;
  endfunction

endpackage

// File: rtl/in_switch_skid.sv
// Two-entry skid buffer with a registered ready. Ready reflects "not full"
// as of the next cycle, so a push and pop together at one entry keep the
// stream moving at one beat per cycle without a bubble.
module in_switch_skid #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [PW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_pop_i
);

  logic [PW-1:0] mem_q [2];
  logic          rd_ptr_q;
  logic          wr_ptr_q;
  logic [1:0]    count_q;
  logic [1:0]    count_d;
  logic          ready_q;
  logic          push_s;
  logic          pop_s;

  assign push_s      = in_valid_i & ready_q;
  assign out_valid_o = (count_q != 2'd0);
  assign pop_s       = out_valid_o & out_pop_i;
  assign out_data_o  = mem_q[rd_ptr_q];
  assign in_ready_o  = ready_q;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers, occupancy and the registered not-full ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
      if (push_s) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: rtl/in_switch.sv
// Packet-granular 1-to-3 stream demultiplexer. The destination and the
// weight_switch sideband are taken from a packet's first beat and carried
// with every beat through a 2-entry skid buffer; all outputs show the buffer
// head and only the addressed lane raises tvalid.
// Optional feature macro: IN_SWITCH_DROP_EN (select 3 drops the packet and
// raises the sticky route_err output).
module in_switch
  import in_switch_pkg::*;
#(
  parameter int DWIDTH = 128,
  parameter int LASTW  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ROUTE_W-1:0] route_sel,
  input  logic               weight_switch,
  input  logic [DWIDTH-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [LASTW-1:0]   s_axis_tlast,
  output logic [DWIDTH-1:0]  m_axis_tdata_0,
  output logic               m_axis_tvalid_0,
  input  logic               m_axis_tready_0,
  output logic [LASTW-1:0]   m_axis_tlast_0,
  output logic [DWIDTH-1:0]  m_axis_tdata_1,
  output logic               m_axis_tvalid_1,
  input  logic               m_axis_tready_1,
  output logic [LASTW-1:0]   m_axis_tlast_1,
  output logic [DWIDTH-1:0]  m_axis_tdata_2,
  output logic               m_axis_tvalid_2,
  input  logic               m_axis_tready_2,
  output logic [LASTW-1:0]   m_axis_tlast_2,
  output logic               weight_switch_out
`ifdef IN_SWITCH_DROP_EN
 ,output logic               route_err
`endif
);

  localparam int PW = ROUTE_W + 1 + DWIDTH + LASTW;

  state_e             state_q, state_d;
  logic [ROUTE_W-1:0] dest_q, dest_d;
  logic               ws_q, ws_d;
  logic [ROUTE_W-1:0] beat_dest_s;
  logic               beat_ws_s;
  logic               beat_drop_s;
  logic               last_s;
  logic               accept_s;
  logic               buf_ready_s;
  logic               head_valid_s;
  logic               pop_s;
  logic [PW-1:0]      head_data_s;
  logic [ROUTE_W-1:0] head_dest_s;
  logic               head_ws_s;
  logic [DWIDTH-1:0]  head_tdata_s;
  logic [LASTW-1:0]   head_tlast_s;

  assign last_s = |s_axis_tlast;

`ifdef IN_SWITCH_DROP_EN
  // A dropping packet is swallowed regardless of buffer occupancy.
  assign s_axis_tready = (state_q == ST_DROP) ? 1'b1 : buf_ready_s;
`else
  assign s_axis_tready = buf_ready_s;
`endif

  assign accept_s = s_axis_tvalid & s_axis_tready;

  // Packet FSM: first beat latches dest/ws, later beats reuse them.
  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    ws_d        = ws_q;
    beat_dest_s = dest_q;
    beat_ws_s   = ws_q;
    beat_drop_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        beat_dest_s = sat_dest(route_sel);
        beat_ws_s   = weight_switch;
`ifdef IN_SWITCH_DROP_EN
        beat_drop_s = (route_sel == DEST_DROP);
`endif
        if (accept_s) begin
          dest_d = beat_dest_s;
          ws_d   = beat_ws_s;
          if (last_s) begin
            state_d = ST_IDLE;
          end else if (beat_drop_s) begin
            state_d = ST_DROP;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (accept_s && last_s) begin
          state_d = ST_IDLE;
        end
      end
`ifdef IN_SWITCH_DROP_EN
      ST_DROP: begin
        beat_drop_s = 1'b1;
        if (accept_s && last_s) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and per-packet latched destination/sideband.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dest_q  <= DEST_0;
      ws_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      ws_q    <= ws_d;
    end
  end

`ifdef IN_SWITCH_DROP_EN
  logic route_err_q;

  // Sticky error flag: set by any dropped beat, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      route_err_q <= 1'b0;
    end else if (accept_s && beat_drop_s) begin
      route_err_q <= 1'b1;
    end
  end

  assign route_err = route_err_q;
`endif

  in_switch_skid #(.PW(PW)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   ({beat_dest_s, beat_ws_s, s_axis_tdata, s_axis_tlast}),
    .in_valid_i  (s_axis_tvalid & ~beat_drop_s),
    .in_ready_o  (buf_ready_s),
    .out_data_o  (head_data_s),
    .out_valid_o (head_valid_s),
    .out_pop_i   (pop_s)
  );

  assign {head_dest_s, head_ws_s, head_tdata_s, head_tlast_s} = head_data_s;

  // Only the ready of the lane the head is addressed to can pop it.
  assign pop_s = ((head_dest_s == DEST_0) & m_axis_tready_0) |
                 ((head_dest_s == DEST_1) & m_axis_tready_1) |
                 ((head_dest_s == DEST_2) & m_axis_tready_2);

  assign m_axis_tvalid_0 = head_valid_s & (head_dest_s == DEST_0);
  assign m_axis_tvalid_1 = head_valid_s & (head_dest_s == DEST_1);
  assign m_axis_tvalid_2 = head_valid_s & (head_dest_s == DEST_2);

  assign m_axis_tdata_0 = head_tdata_s;
  assign m_axis_tdata_1 = head_tdata_s;
  assign m_axis_tdata_2 = head_tdata_s;

  assign m_axis_tlast_0 = m_axis_tvalid_0 ? head_tlast_s : {LASTW{1'b0}};
  assign m_axis_tlast_1 = m_axis_tvalid_1 ? head_tlast_s : {LASTW{1'b0}};
  assign m_axis_tlast_2 = m_axis_tvalid_2 ? head_tlast_s : {LASTW{1'b0}};

  assign weight_switch_out = head_ws_s;

endmodule

// File: tb/tb_in_switch.sv
// Self-checking bench for in_switch: directed packet scenarios followed by
// randomized packets and output back-pressure, checked against a packet-level
// reference model (one global queue of expected beats in arrival order).
module tb_in_switch;

  localparam int DW = 128;
  localparam int LW = 1;
`ifdef IN_SWITCH_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]    dest;
    logic          ws;
    logic [DW-1:0] data;
    logic [LW-1:0] last;
    int            acc_cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0]    route_sel = 2'd0;
  logic          weight_switch = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [LW-1:0] s_tlast = '0;
  logic [2:0]    m_tready = 3'b111;
  logic [DW-1:0] m_tdata0, m_tdata1, m_tdata2;
  logic          m_tvalid0, m_tvalid1, m_tvalid2;
  logic [LW-1:0] m_tlast0, m_tlast1, m_tlast2;
  logic          ws_out;
  logic          rerr;

  logic [DW-1:0] m_tdata_a [3];
  logic [LW-1:0] m_tlast_a [3];
  logic [2:0]    m_tvalid;

  assign m_tdata_a[0] = m_tdata0;
  assign m_tdata_a[1] = m_tdata1;
  assign m_tdata_a[2] = m_tdata2;
  assign m_tlast_a[0] = m_tlast0;
  assign m_tlast_a[1] = m_tlast1;
  assign m_tlast_a[2] = m_tlast2;
  assign m_tvalid     = {m_tvalid2, m_tvalid1, m_tvalid0};

  in_switch #(.DWIDTH(DW), .LASTW(LW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .route_sel         (route_sel),
    .weight_switch     (weight_switch),
    .s_axis_tdata      (s_tdata),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (s_tready),
    .s_axis_tlast      (s_tlast),
    .m_axis_tdata_0    (m_tdata0),
    .m_axis_tvalid_0   (m_tvalid0),
    .m_axis_tready_0   (m_tready[0]),
    .m_axis_tlast_0    (m_tlast0),
    .m_axis_tdata_1    (m_tdata1),
    .m_axis_tvalid_1   (m_tvalid1),
    .m_axis_tready_1   (m_tready[1]),
    .m_axis_tlast_1    (m_tlast1),
    .m_axis_tdata_2    (m_tdata2),
    .m_axis_tvalid_2   (m_tvalid2),
    .m_axis_tready_2   (m_tready[2]),
    .m_axis_tlast_2    (m_tlast2),
    .weight_switch_out (ws_out)
`ifdef IN_SWITCH_DROP_EN
   ,.route_err         (rerr)
`endif
  );

`ifndef IN_SWITCH_DROP_EN
  assign rerr = 1'b0;
`endif

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    acc_cnt = 0;
  bit    rnd_rdy = 1'b0;
  bit    lat_chk = 1'b0;
  bit    mon_en = 1'b1;
  beat_t exp_q [$];

  // Current-packet context of the reference model.
  logic [1:0] pkt_dest = 2'd0;
  logic       pkt_ws = 1'b0;
  bit         pkt_drop = 1'b0;

  task automatic chk(input string tag, input logic [DW+7:0] obs, input logic [DW+7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) m_tready = 3'($urandom);
  endtask

  // Offer one beat until accepted; the model records it unless dropped.
  task automatic put_beat(input logic [1:0] sel, input logic ws, input bit last,
                          input bit first, output int tries);
    beat_t e;
    bit    done;
    s_tdata       = {$urandom, $urandom, $urandom, $urandom};
    s_tlast       = LW'(last);
    route_sel     = sel;
    weight_switch = ws;
    s_tvalid      = 1'b1;
    if (first) begin
      pkt_drop = DROP_EN && (sel == 2'd3);
      pkt_dest = (sel == 2'd3) ? 2'd2 : sel;
      pkt_ws   = ws;
    end
    tries = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      tries++;
      if (s_tready) begin
        acc_cnt++;
        if (!pkt_drop) begin
          e.dest    = pkt_dest;
          e.ws      = pkt_ws;
          e.data    = s_tdata;
          e.last    = s_tlast;
          e.acc_cyc = cyc;
          exp_q.push_back(e);
        end
        done = 1'b1;
      end else if (tries >= 200) begin
        chk("accept_timeout", 1'b0, 1'b1);
        done = 1'b1;
      end
      step();
    end
  endtask

  // mid_sel < 0 means random route_sel/weight_switch on non-first beats.
  task automatic send_pkt(input logic [1:0] sel, input logic ws, input int n,
                          input int mid_sel, output int max_tries);
    int         t;
    logic [1:0] s;
    logic       w;
    max_tries = 0;
    for (int i = 0; i < n; i++) begin
      s = (i == 0) ? sel : ((mid_sel < 0) ? 2'($urandom) : 2'(mid_sel));
      w = (i == 0) ? ws : 1'($urandom);
      put_beat(s, w, (i == n - 1), (i == 0), t);
      if (t > max_tries) max_tries = t;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    rnd_rdy  = 1'b0;
    m_tready = 3'b111;
    while (exp_q.size() != 0 && b < 200) begin
      step();
      b++;
    end
    step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]    hold_v = 3'b000;
  logic [DW-1:0] hold_d [3];

  // Output monitor: scoreboard on every handshake, AXI hold rule, idle tlast.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && mon_en) begin
      if (m_tvalid != 3'b000) chk("valid_onehot", $onehot(m_tvalid), 1'b1);
      for (int k = 0; k < 3; k++) begin
        if (hold_v[k]) begin
          chk("hold_valid", m_tvalid[k], 1'b1);
          chk("hold_data", m_tdata_a[k], hold_d[k]);
        end
        if (!m_tvalid[k]) chk("idle_tlast", m_tlast_a[k], '0);
        if (m_tvalid[k] && m_tready[k]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("dest", k, e.dest);
            chk("data", m_tdata_a[k], e.data);
            chk("tlast", m_tlast_a[k], e.last);
            chk("ws_out", ws_out, e.ws);
            if (lat_chk) chk("latency", cyc - e.acc_cyc, 1);
          end
        end
        hold_v[k] <= m_tvalid[k] & ~m_tready[k];
        hold_d[k] <= m_tdata_a[k];
      end
    end else begin
      hold_v <= 3'b000;
    end
  end

  initial begin
    int t;
    int mt;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tready", s_tready, 1'b0);
    chk("rst_valid", m_tvalid, 3'b000);
    chk("rst_tdata", m_tdata0, '0);
    chk("rst_ws_out", ws_out, 1'b0);
    chk("rst_route_err", rerr, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("tready_before_edge", s_tready, 1'b0);
    step();
    @(negedge clk);
    chk("tready_after_edge", s_tready, 1'b1);
    step();

    // 4-beat packet to lane 1, all ready: 1-cycle latency, back-to-back
    lat_chk = 1'b1;
    send_pkt(2'd1, 1'b1, 4, 1, mt);
    chk("t1_full_rate", mt, 1);
    drain();
    lat_chk = 1'b0;

    // route_sel toggles mid-packet; following packet goes to lane 0
    send_pkt(2'd1, 1'b0, 4, 0, mt);
    send_pkt(2'd0, 1'b1, 3, 1, mt);
    drain();

    // Lane 2 stalled for 5 cycles: input stops after 2 beats
    m_tready = 3'b011;
    acc_cnt  = 0;
    fork
      send_pkt(2'd2, 1'b1, 6, -1, mt);
      begin
        repeat (5) @(negedge clk);
        chk("stall_accepted", acc_cnt, 2);
        chk("stall_tready", s_tready, 1'b0);
        @(posedge clk);
        #1 m_tready = 3'b111;
      end
    join
    drain();

    // Back-to-back single-beat packets at full rate
    lat_chk = 1'b1;
    send_pkt(2'd0, 1'b1, 1, -1, mt); chk("single0_rate", mt, 1);
    send_pkt(2'd1, 1'b0, 1, -1, mt); chk("single1_rate", mt, 1);
    send_pkt(2'd2, 1'b1, 1, -1, mt); chk("single2_rate", mt, 1);
    send_pkt(2'd0, 1'b0, 1, -1, mt); chk("single3_rate", mt, 1);
    drain();
    lat_chk = 1'b0;

    // Async reset mid-packet, then a sel=2 beat starts a fresh packet
    put_beat(2'd1, 1'b1, 1'b0, 1'b1, t);
    put_beat(2'd1, 1'b1, 1'b0, 1'b0, t);
    s_tvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", m_tvalid, 3'b000);
    chk("mid_rst_tready", s_tready, 1'b0);
    chk("mid_rst_tlast", m_tlast1, '0);
    chk("mid_rst_tdata", m_tdata1, '0);
    chk("mid_rst_ws", ws_out, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    send_pkt(2'd2, 1'b0, 2, 1, mt);
    drain();

    // Select 3: saturates to lane 2, or dropped with route_err
    send_pkt(2'd3, 1'b1, 3, -1, mt);
    drain();
`ifdef IN_SWITCH_DROP_EN
    chk("route_err_set", rerr, 1'b1);
    send_pkt(2'd3, 1'b0, 1, -1, mt);
    chk("drop_single_rate", mt, 1);
`endif
    send_pkt(2'd0, 1'b1, 2, -1, mt);
    drain();

    // Randomized packets with random back-pressure
    rnd_rdy = 1'b1;
    for (int p = 0; p < 60; p++) begin
      send_pkt(2'($urandom), 1'($urandom), 1 + int'($urandom_range(4, 0)), -1, mt);
      if ($urandom_range(3, 0) == 0) step();
    end
    drain();
`ifdef IN_SWITCH_DROP_EN
    chk("route_err_sticky", rerr, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
